// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  // Operation codes presented on the op input by the EX-stage decoder
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Widest operand supported by the all-ones divide-by-zero LO constant
  localparam int MAX_WIDTH = 64;

  // LO result of a divide by zero (all ones); sliced to WIDTH by the user
  localparam logic [MAX_WIDTH-1:0] DIV0_LO_ALL = '1;

  // Signed variants (MULT, DIV) have op[0] clear
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Divide variants (DIV, DIVU) have op[1] set
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude extraction at capture, sign restore in FIX.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, pass through otherwise
  always_comb begin
    res = neg ? -val : val;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers.
// Latency: WIDTH+1 cycles from start to done (1 cycle for divide by zero).
// Backpressure: stall = busy & (start | mf_req); a start while busy is ignored and must be held.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e             state;
  state_e             state_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               div0_nxt;

  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   a_reg;      // multiplicand magnitude, or raw dividend on divide by zero
  logic [WIDTH-1:0]   b_reg;      // divisor magnitude
  logic [2*WIDTH-1:0] acc;        // product, or {remainder, dividend/quotient}
  logic               is_div_r;
  logic               neg_q_r;    // result (product/quotient) must be negated
  logic               neg_r_r;    // remainder must be negated (dividend was negative)
  logic               div0_r;

  // Capture-side signals
  logic               sgn_op;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;

  // Iteration-step signals
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [2*WIDTH-1:0] div_next;

  // FIX-side signals
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand sign decode and divide-by-zero detection at issue
  always_comb begin
    sgn_op   = op_is_signed(op);
    sign_a   = sgn_op & rs_val[WIDTH-1];
    sign_b   = sgn_op & rt_val[WIDTH-1];
    div_zero = op_is_div(op) && (rt_val == '0);
  end

  muldiv_signfix #(.W(WIDTH)) u_rs_mag (
    .val (rs_val),
    .neg (sign_a),
    .res (rs_mag)
  );

  muldiv_signfix #(.W(WIDTH)) u_rt_mag (
    .val (rt_val),
    .neg (sign_b),
    .res (rt_mag)
  );

  // One shift-add multiply step and one restoring divide step, computed from acc
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    // Shifted remainder needs one extra bit: it can reach 2*divisor-1
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = rem_sh - {1'b0, b_reg};
    q_bit    = ~trial[WIDTH];
    div_next = {(q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], q_bit};
  end

  muldiv_signfix #(.W(2*WIDTH)) u_prod_fix (
    .val (acc),
    .neg (neg_q_r),
    .res (prod_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_quot_fix (
    .val (acc[WIDTH-1:0]),
    .neg (neg_q_r),
    .res (quot_fix)
  );

  muldiv_signfix #(.W(WIDTH)) u_rem_fix (
    .val (acc[2*WIDTH-1:WIDTH]),
    .neg (neg_r_r),
    .res (rem_fix)
  );

  // State register plus registered status flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      div0  <= div0_nxt;
    end
  end

  // Next-state logic; divide by zero skips the iterations entirely
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = div_zero ? FIX : CALC;
        end
      end
      CALC: begin
        if (count == '0) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: next values of the registered flags, plus the combinational stall
  always_comb begin
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state == FIX);
    div0_nxt = (state == FIX) && div0_r;
    stall    = busy & (start | mf_req);
  end

  // Datapath: operand capture, iteration, and HI/LO update in FIX
  always_ff @(posedge clock) begin
    if (!reset) begin
      count    <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      div0_r   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count    <= CW'(WIDTH - 1);
            is_div_r <= op_is_div(op);
            neg_q_r  <= sign_a ^ sign_b;
            neg_r_r  <= sign_a;
            div0_r   <= div_zero;
            a_reg    <= div_zero ? rs_val : rs_mag;
            b_reg    <= rt_mag;
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend
            acc      <= {{WIDTH{1'b0}}, (op_is_div(op) ? rs_mag : rt_mag)};
          end
        end
        CALC: begin
          acc <= is_div_r ? div_next : mul_next;
          if (count != '0) begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          if (div0_r) begin
            lo <= DIV0_LO_ALL[WIDTH-1:0];
            hi <= a_reg;
          end else if (is_div_r) begin
            lo <= quot_fix;
            hi <= rem_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
